uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 114 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: the byte width, the arbiter FSM
// state encoding and a small index helper.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } tx_arb_state_t;

  // Next index in a ring of n slots, wrapping n-1 back to 0.
  function automatic int wrapInc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or above the pointer wins,
// with the search wrapping past NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     grant_idx_o
);

  int           cand;
  logic [IDW-1:0] candIdx;
  logic         found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    candIdx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand    = (int'(ptr_i) + k) % NUM_REQ;
      candIdx = IDW'(cand);
      if (!found && req_i[candIdx]) begin
        found            = 1'b1;
        grant_o[candIdx] = 1'b1;
        grant_idx_o      = candIdx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ requesters; a grant is held for a whole packet
// and the round-robin pointer only moves once the packet's last byte has gone out.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]         tx_data,
  output logic                           tx_data_valid,
  input  logic                           tx_data_ready,
  output logic                           busy,
  output logic [IDW-1:0]                 grant_id
);

  tx_arb_state_t          state_q, state_d;
  logic [IDW-1:0]         grant_q, grant_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [UART_BYTE_W-1:0] data_q, data_d;
  logic                   last_q, last_d;

  logic [UART_BYTE_W-1:0] reqBytes [NUM_REQ];
  logic [NUM_REQ-1:0]     arbGrant;
  logic [IDW-1:0]         arbIdx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign reqBytes[i] = req_data[UART_BYTE_W*i +: UART_BYTE_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_arbiter (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (arbGrant),
    .grant_idx_o (arbIdx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    last_d    = last_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if ((|arbGrant) && tx_data_ready) begin
          grant_d = arbIdx;
          state_d = S_LOAD;
        end
      end
      // The grant stays locked here even if its owner stalls, so packets never interleave.
      S_LOAD: begin
        if (req_valid[grant_q]) begin
          data_d    = reqBytes[grant_q];
          last_d    = req_last[grant_q];
          req_ready = NUM_REQ'(1) << grant_q;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!tx_data_ready) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (tx_data_ready) begin
          if (last_q) begin
            ptr_d   = IDW'(wrapInc(int'(grant_q), NUM_REQ));
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx_data       = data_q;
  assign tx_data_valid = (state_q == S_ISSUE);
  assign busy          = (state_q != S_IDLE);
  assign grant_id      = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx stand-in, per-requester
// byte queues and a monitor that logs every launched byte.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
  localparam int FRAME   = 10;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b1;
  logic [8*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_last;
  logic [NUM_REQ-1:0]     req_ready;
  logic [7:0]             tx_data;
  logic                   tx_data_valid;
  logic                   tx_data_ready;
  logic                   busy;
  logic [IDW-1:0]         grant_id;

  int checkCount = 0;
  int passCount  = 0;

  logic [8:0] pktMem [NUM_REQ][32];
  int         qHead [NUM_REQ];
  int         qTail [NUM_REQ];

  logic [7:0]     txLog [64];
  logic [IDW-1:0] txGid [64];
  int txCount = 0;
  int readyCnt [NUM_REQ];
  int readyTotal = 0;
  int multiReady = 0;
  int wrongReady = 0;
  int validNotReady = 0;
  int uartCnt;
  int base;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  // Transmitter stand-in: ready stays low for a cycle after reset, then drops for a frame per launch.
  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_data_ready <= 1'b0;
      uartCnt       <= 2;
    end else if (tx_data_valid) begin
      tx_data_ready <= 1'b0;
      uartCnt       <= FRAME;
    end else if (uartCnt > 0) begin
      uartCnt <= uartCnt - 1;
      if (uartCnt == 1) tx_data_ready <= 1'b1;
    end
  end

  // Logs launched bytes and pops a requester's queue when its byte is accepted.
  always @(negedge clk) begin
    if (rstn) begin
      if (tx_data_valid) begin
        txLog[txCount] = tx_data;
        txGid[txCount] = grant_id;
        txCount++;
        if (!tx_data_ready) validNotReady++;
      end
      if ($countones(req_ready) > 1) multiReady++;
      if ((req_ready & ~(4'b0001 << grant_id)) != 4'b0000) wrongReady++;
      readyTotal += $countones(req_ready);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) begin
          readyCnt[i]++;
          qHead[i]++;
        end
      end
    end
  end

  // Requester drivers: present the head of each queue just after every rising edge.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      qHead[i]    = 0;
      qTail[i]    = 0;
      readyCnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (qHead[i] < qTail[i]) begin
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = pktMem[i][qHead[i]][7:0];
          req_last[i]         = pktMem[i][qHead[i]][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] data, input logic last);
    pktMem[idx][qTail[idx]] = {last, data};
    qTail[idx]++;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic waitTx(input string tag, input int target, input int budget);
    int n = 0;
    while (txCount < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(txCount), 32'(target));
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int  n = 0;
    bit  pending = 1'b1;
    while (pending && n < budget) begin
      tick();
      n++;
      pending = busy;
      for (int i = 0; i < NUM_REQ; i++) if (qHead[i] < qTail[i]) pending = 1'b1;
    end
    checkOutput(tag, 32'(busy), 32'(0));
  endtask

  task automatic flushQueues();
    for (int i = 0; i < NUM_REQ; i++) qHead[i] = qTail[i];
  endtask

  initial begin
    $display("[TB] uart_tx_arbiter directed run");
    #2 rstn = 1'b0;
    repeat (2) tick();
    checkOutput("rst_req_ready", 32'(req_ready), 32'(0));
    checkOutput("rst_tx_data", 32'(tx_data), 32'(0));
    checkOutput("rst_tx_valid", 32'(tx_data_valid), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_grant_id", 32'(grant_id), 32'(0));

    // Single-byte packet from requester 2, with the transmitter not yet ready at release.
    applyStimulus(2, 8'h41, 1'b1);
    @(posedge clk);
    #1 rstn = 1'b1;
    tick();
    tick();
    checkOutput("t1_no_grant_not_ready", 32'(busy), 32'(0));
    tick();
    checkOutput("t1_busy", 32'(busy), 32'(1));
    checkOutput("t1_grant", 32'(grant_id), 32'(2));
    checkOutput("t1_req_ready", 32'(req_ready), 32'(4'b0100));
    tick();
    checkOutput("t1_valid", 32'(tx_data_valid), 32'(1));
    checkOutput("t1_data", 32'(tx_data), 32'(8'h41));
    checkOutput("t1_req_ready_gone", 32'(req_ready), 32'(0));
    tick();
    checkOutput("t1_valid_single", 32'(tx_data_valid), 32'(0));
    checkOutput("t1_busy_held", 32'(busy), 32'(1));
    waitIdle("t1_idle", 100);
    checkOutput("t1_count", 32'(txCount), 32'(1));
    checkOutput("t1_ready_pulses", 32'(readyCnt[2]), 32'(1));
    checkOutput("t1_grant_kept", 32'(grant_id), 32'(2));

    // Fresh pointer: all four requesters at once, then requesters 1 and 3.
    rstn = 1'b0;
    repeat (2) tick();
    base = txCount;
    applyStimulus(0, 8'h10, 1'b1);
    applyStimulus(1, 8'h11, 1'b1);
    applyStimulus(2, 8'h12, 1'b1);
    applyStimulus(3, 8'h13, 1'b1);
    @(posedge clk);
    #1 rstn = 1'b1;
    waitTx("t2_wait4", base + 4, 500);
    waitIdle("t2_idle", 100);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t2_order%0d", k), 32'(txLog[base+k]), 32'(8'h10 + k));
    end
    base = txCount;
    applyStimulus(1, 8'h11, 1'b1);
    applyStimulus(3, 8'h13, 1'b1);
    waitTx("t2b_wait2", base + 2, 300);
    waitIdle("t2b_idle", 100);
    checkOutput("t2b_first", 32'(txLog[base]), 32'(8'h11));
    checkOutput("t2b_second", 32'(txLog[base+1]), 32'(8'h13));

    // Three-byte packet from requester 0 is not broken up by requester 1.
    base = txCount;
    applyStimulus(0, 8'h41, 1'b0);
    applyStimulus(0, 8'h42, 1'b0);
    applyStimulus(0, 8'h43, 1'b1);
    applyStimulus(1, 8'h5a, 1'b1);
    waitTx("t3_wait4", base + 4, 500);
    waitIdle("t3_idle", 100);
    checkOutput("t3_byteA", 32'(txLog[base]), 32'(8'h41));
    checkOutput("t3_byteB", 32'(txLog[base+1]), 32'(8'h42));
    checkOutput("t3_byteC", 32'(txLog[base+2]), 32'(8'h43));
    checkOutput("t3_byteZ", 32'(txLog[base+3]), 32'(8'h5a));
    checkOutput("t3_gidA", 32'(txGid[base]), 32'(0));
    checkOutput("t3_gidC", 32'(txGid[base+2]), 32'(0));
    checkOutput("t3_gidZ", 32'(txGid[base+3]), 32'(1));

    // Requester 0 stalls mid-packet; requester 3 must wait for the whole packet.
    base = txCount;
    applyStimulus(0, 8'h50, 1'b0);
    waitTx("t4_first", base + 1, 200);
    applyStimulus(3, 8'h70, 1'b1);
    repeat (50) tick();
    checkOutput("t4_locked_count", 32'(txCount), 32'(base + 1));
    checkOutput("t4_locked_busy", 32'(busy), 32'(1));
    checkOutput("t4_locked_gid", 32'(grant_id), 32'(0));
    applyStimulus(0, 8'h51, 1'b1);
    waitTx("t4_rest", base + 3, 300);
    waitIdle("t4_idle", 100);
    checkOutput("t4_second", 32'(txLog[base+1]), 32'(8'h51));
    checkOutput("t4_third", 32'(txLog[base+2]), 32'(8'h70));

    // Reset while byte 2 of a packet is on the wire.
    base = txCount;
    applyStimulus(2, 8'h60, 1'b0);
    applyStimulus(2, 8'h61, 1'b0);
    applyStimulus(2, 8'h62, 1'b1);
    waitTx("t5_two", base + 2, 300);
    tick();
    tick();
    checkOutput("t5_pre_busy", 32'(busy), 32'(1));
    checkOutput("t5_pre_data", 32'(tx_data), 32'(8'h61));
    rstn = 1'b0;
    #1;
    checkOutput("t5_rst_busy", 32'(busy), 32'(0));
    checkOutput("t5_rst_data", 32'(tx_data), 32'(0));
    checkOutput("t5_rst_gid", 32'(grant_id), 32'(0));
    checkOutput("t5_rst_valid", 32'(tx_data_valid), 32'(0));
    checkOutput("t5_rst_ready", 32'(req_ready), 32'(0));
    flushQueues();
    repeat (2) tick();
    applyStimulus(1, 8'h77, 1'b1);
    @(posedge clk);
    #1 rstn = 1'b1;
    waitTx("t5_after", base + 3, 300);
    waitIdle("t5_idle", 100);
    checkOutput("t5_after_data", 32'(txLog[base+2]), 32'(8'h77));
    checkOutput("t5_after_gid", 32'(txGid[base+2]), 32'(1));

    // Back-to-back eight-byte packet from requester 3, then requester 0.
    base = txCount;
    for (int k = 0; k < 8; k++) applyStimulus(3, 8'h80 + 8'(k), k == 7);
    applyStimulus(0, 8'h90, 1'b1);
    waitTx("t6_all", base + 9, 1000);
    waitIdle("t6_idle", 100);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("t6_byte%0d", k), 32'(txLog[base+k]), 32'(8'h80 + k));
    end
    checkOutput("t6_tail", 32'(txLog[base+8]), 32'(8'h90));

    checkOutput("inv_valid_not_ready", 32'(validNotReady), 32'(0));
    checkOutput("inv_multi_ready", 32'(multiReady), 32'(0));
    checkOutput("inv_wrong_ready", 32'(wrongReady), 32'(0));
    checkOutput("inv_ready_per_byte", 32'(readyTotal), 32'(txCount));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
